// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST controller: FSM states, LFSR seed,
// feedback-polynomial lookup and the 16-bit vector index type.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [15:0] vec_idx_t;

  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  // Galois feedback taps (x^w term dropped) for every width the LFSR or MISR can take.
  function automatic logic [31:0] taps_for_width(input int unsigned width);
    case (width)
      2:       return 32'h0000_0003;
      4:       return 32'h0000_0009;
      8:       return 32'h0000_001D;
      16:      return 32'h0000_6801;
      32:      return 32'h0040_0007;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Stimulus/response and status bundle between the BIST controller (master) and
// the gate under test plus its supervisor (slave).
interface gate_bist_if #(
  parameter int unsigned N = 4
);
  import gate_bist_pkg::*;

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] F;
  logic         busy;
  logic         done;
  logic         pass;
  vec_idx_t     fail_idx;
  logic [N-1:0] sig;

  modport master (
    input  start, F,
    output A, B, busy, done, pass, fail_idx, sig
  );

  modport slave (
    output start, F,
    input  A, B, busy, done, pass, fail_idx, sig
  );

endinterface

// File: rtl/gate_bist_lfsr.sv
// Galois shift-left LFSR used as the stimulus source; resets to zero so the
// operands it feeds read 0 until a run loads the seed.
module gate_bist_lfsr
  import gate_bist_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         advance_i,
  output logic [W-1:0] q_o
);

  localparam logic [31:0] TAPS = taps_for_width(W);
  localparam logic [31:0] SEED = LFSR_SEED;

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED[W-1:0];
    end else if (advance_i) begin
      lfsr_d = {lfsr_q[W-2:0], 1'b0} ^ (lfsr_q[W-1] ? TAPS[W-1:0] : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: drives LFSR vectors into an n-bit AND gate, checks F == A&B,
// latches the first failing index. Define GATE_BIST_MISR_EN to compact F into sig.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned SETTLE  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.master bus
);

  localparam int unsigned   W           = 2 * N;
  localparam int unsigned   SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam vec_idx_t      VEC_LAST    = vec_idx_t'(NUM_VEC - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  vec_idx_t      vec_cnt_q, vec_cnt_d;
  vec_idx_t      fail_idx_q, fail_idx_d;
  logic          pass_q, pass_d;
  logic          lfsr_load, lfsr_adv, mismatch;
  logic [W-1:0]  stim;

  gate_bist_lfsr #(
    .W (W)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (lfsr_load),
    .advance_i (lfsr_adv),
    .q_o       (stim)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    vec_cnt_d    = vec_cnt_q;
    fail_idx_d   = fail_idx_q;
    pass_d       = pass_q;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;
    // Case inequality so an X/Z response is treated as a failure.
    mismatch     = (bus.F !== (stim[W-1:N] & stim[N-1:0]));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = APPLY;
          lfsr_load    = 1'b1;
          settle_cnt_d = '0;
          vec_cnt_d    = '0;
          fail_idx_d   = '0;
          pass_d       = 1'b1;
        end
      end
      APPLY: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch && pass_q) begin
          pass_d     = 1'b0;
          fail_idx_d = vec_cnt_q;
        end
        if (vec_cnt_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          state_d      = APPLY;
          lfsr_adv     = 1'b1;
          vec_cnt_d    = vec_cnt_q + 1'b1;
          settle_cnt_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      vec_cnt_q    <= '0;
      fail_idx_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      vec_cnt_q    <= vec_cnt_d;
      fail_idx_q   <= fail_idx_d;
      pass_q       <= pass_d;
    end
  end

`ifdef GATE_BIST_MISR_EN
  localparam logic [31:0] MISR_TAPS = taps_for_width(N);

  logic [N-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == IDLE && bus.start) begin
      sig_d = '0;
    end else if (state_q == CHECK) begin
      sig_d = ({sig_q[N-2:0], 1'b0} ^ (sig_q[N-1] ? MISR_TAPS[N-1:0] : '0)) ^ bus.F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = '0;
`endif

  assign bus.A        = stim[W-1:N];
  assign bus.B        = stim[N-1:0];
  assign bus.busy     = (state_q == APPLY) || (state_q == CHECK);
  assign bus.done     = (state_q == DONE);
  assign bus.pass     = pass_q;
  assign bus.fail_idx = fail_idx_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl (n=4, 16 vectors, settle 1): a table of full runs
// with different gate faults / stray starts, plus reset and abort sequences.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  localparam int unsigned N        = 4;
  localparam int unsigned NUM_VEC  = 16;
  localparam int unsigned SETTLE   = 1;
  localparam int          VEC_CYC  = SETTLE + 1;
  localparam int          DONE_CYC = NUM_VEC * VEC_CYC + 1;

  typedef struct {
    int   mode;
    int   pulseCyc;
    logic expPass;
    int   expFailIdx;
  } scenario_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   fMode = 0;

  logic [N-1:0] expA [NUM_VEC];
  logic [N-1:0] expB [NUM_VEC];
  logic [N-1:0] runSig [5];
  logic [N-1:0] fModel;
  scenario_t    table_q [5];

  gate_bist_if #(.N(N)) bus ();

  gate_bist_ctrl #(
    .N       (N),
    .NUM_VEC (NUM_VEC),
    .SETTLE  (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Gate under test: ideal AND, F[0] stuck-at-0, or all-zero only on the E/3 vector.
  always_comb begin
    fModel = bus.A & bus.B;
    if (fMode == 1) begin
      fModel[0] = 1'b0;
    end else if (fMode == 2 && bus.A == 4'hE && bus.B == 4'h3) begin
      fModel = '0;
    end
  end
  assign bus.F = fModel;

  function automatic logic [7:0] lfsrStep(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [N-1:0] misrStep(input logic [N-1:0] s, input logic [N-1:0] f);
    return ({s[N-2:0], 1'b0} ^ (s[N-1] ? 4'h9 : 4'h0)) ^ f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_A"},        32'(bus.A),        32'h0);
    checkOutput({tag, "_B"},        32'(bus.B),        32'h0);
    checkOutput({tag, "_busy"},     32'(bus.busy),     32'h0);
    checkOutput({tag, "_done"},     32'(bus.done),     32'h0);
    checkOutput({tag, "_pass"},     32'(bus.pass),     32'h0);
    checkOutput({tag, "_fail_idx"}, 32'(bus.fail_idx), 32'h0);
    checkOutput({tag, "_sig"},      32'(bus.sig),      32'h0);
  endtask

  // Full run from IDLE: start sampled at edge 0, cycle c is the period after edge c-1.
  task automatic applyStimulus(input scenario_t sc, output logic [N-1:0] sigOut);
    logic [N-1:0] expSig;
    logic [N-1:0] resp;
    int           v;
    expSig = '0;
    fMode  = sc.mode;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 3; c++) begin
      @(negedge clk);
      bus.start = (c == sc.pulseCyc);
      if (c < DONE_CYC) begin
        v = (c - 1) / VEC_CYC;
        checkOutput($sformatf("A_v%0d", v), 32'(bus.A), 32'(expA[v]));
        checkOutput($sformatf("B_v%0d", v), 32'(bus.B), 32'(expB[v]));
        checkOutput($sformatf("busy_c%0d", c), 32'(bus.busy), 32'h1);
        if ((c - 1) % VEC_CYC == SETTLE) begin
          resp = expA[v] & expB[v];
          if (sc.mode == 1) resp[0] = 1'b0;
          if (sc.mode == 2 && v == 1) resp = '0;
          expSig = misrStep(expSig, resp);
        end
      end else begin
        checkOutput($sformatf("busy_c%0d", c), 32'(bus.busy), 32'h0);
      end
      checkOutput($sformatf("done_c%0d", c), 32'(bus.done), 32'(c == DONE_CYC));
      if (c == DONE_CYC) begin
        checkOutput("A_hold", 32'(bus.A), 32'(expA[NUM_VEC-1]));
        checkOutput("pass", 32'(bus.pass), 32'(sc.expPass));
        checkOutput("fail_idx", 32'(bus.fail_idx), 32'(sc.expFailIdx));
`ifdef GATE_BIST_MISR_EN
        checkOutput("sig_model", 32'(bus.sig), 32'(expSig));
`else
        checkOutput("sig_off", 32'(bus.sig), 32'h0);
`endif
        sigOut = bus.sig;
      end
    end
    bus.start = 1'b0;
    checkOutput("pass_held", 32'(bus.pass), 32'(sc.expPass));
    checkOutput("fail_idx_held", 32'(bus.fail_idx), 32'(sc.expFailIdx));
  endtask

  initial begin
    logic [7:0]   s;
    logic [N-1:0] dummySig;
    bus.start = 1'b0;

    s = 8'hFF;
    for (int v = 0; v < NUM_VEC; v++) begin
      expA[v] = s[7:4];
      expB[v] = s[3:0];
      s = lfsrStep(s);
    end

    table_q[0] = '{mode: 0, pulseCyc: 0,  expPass: 1'b1, expFailIdx: 0};
    table_q[1] = '{mode: 1, pulseCyc: 0,  expPass: 1'b0, expFailIdx: 0};
    table_q[2] = '{mode: 2, pulseCyc: 0,  expPass: 1'b0, expFailIdx: 1};
    table_q[3] = '{mode: 0, pulseCyc: 5,  expPass: 1'b1, expFailIdx: 0};
    table_q[4] = '{mode: 0, pulseCyc: DONE_CYC, expPass: 1'b1, expFailIdx: 0};

    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("idle");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(table_q[i], runSig[i]);
    end

`ifdef GATE_BIST_MISR_EN
    checkOutput("sig_repeat", 32'(runSig[3]), 32'(runSig[0]));
    checkOutput("sig_nonzero", 32'(runSig[0] != '0), 32'h1);
    checkOutput("sig_stuck_differs", 32'(runSig[1] != runSig[0]), 32'h1);
`endif

    // Abort mid-run: reset takes effect without waiting for a clock edge.
    fMode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checkOutput("busy_before_abort", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("abort");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(bus.done), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("abort_idle");

    applyStimulus(table_q[0], dummySig);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test controller that drives stimulus into an n-bit two-input gate (A, B in; F out) and checks its response in hardware. A run generates pseudo-random vector pairs from an LFSR and waits a fixed settle time. It then compares F against the expected bitwise AND, records the first failing vector, and optionally compacts all responses into a signature. The block sits beside the gate under test and replaces the simulation-only stimulus/check flow with a synthesizable one.

## Interface
- n, 4, operand width; legal values 2, 4, 8, 16 (LFSR is 2n bits)
- NUM_VEC, 16, vectors per run, 1..65535
- SETTLE, 1, cycles A/B are held before F is sampled, ≥1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE only
- A  out  n  stimulus operand A, registered
- B  out  n  stimulus operand B, registered
- F  in  n  response from gate under test
- busy  out  1  high from the cycle after start is accepted through the last CHECK
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 = no mismatch in last run; held until next start
- fail_idx  out  16  index of first mismatching vector; held
- sig  out  n  MISR signature of last run; held

## Operation
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE: on start=1, the following all load at the next edge and state goes to APPLY:
  - LFSR ← LFSR_SEED (all ones); A ← lfsr[2n-1:n], B ← lfsr[n-1:0]
  - vec_cnt, settle_cnt, sig, fail_idx ← 0; pass ← 1; busy ← 1
- APPLY: hold A/B for SETTLE cycles (settle_cnt counts 0..SETTLE-1), then go to CHECK.
- CHECK (1 cycle): sample F and compare to A&B.
  - On mismatch with pass=1: pass ← 0, fail_idx ← vec_cnt. Later mismatches do not change fail_idx.
  - MISR update (when enabled).
  - If vec_cnt = NUM_VEC-1, go to DONE. Otherwise advance LFSR, load new A/B, vec_cnt++, settle_cnt ← 0, go to APPLY.
- DONE: done=1, busy=0, then IDLE. A/B keep the last vector.
- LFSR: Galois, shift left. lfsr_next = {lfsr[2n-2:0],0} ^ (lfsr[2n-1] ? LFSR_TAPS : 0). For 2n=8, taps = 8'h1D (x^8+x^4+x^3+x^2+1).
- MISR: sig_next = ({sig[n-2:0],0} ^ (sig[n-1] ? MISR_TAPS : 0)) ^ F.
- X/Z on F in CHECK counts as a mismatch (case-inequality semantics).

## Timing
- Reset values: A=0, B=0, busy=0, done=0, pass=0, fail_idx=0, sig=0; state IDLE.
- Start accepted at edge 0: first vector is on A/B during cycle 1.
- Each vector occupies SETTLE+1 cycles. The last CHECK is in cycle NUM_VEC·(SETTLE+1), and done is high in cycle NUM_VEC·(SETTLE+1)+1.
- start while busy or in DONE is ignored; a new start is accepted the cycle after DONE.
- rst_n low mid-run aborts immediately (asynchronous): all outputs go to reset values and no done pulse is produced.
- vec_cnt does not wrap; NUM_VEC=1 gives a single APPLY/CHECK.

## Configuration
- GATE_BIST_MISR_EN defined: MISR register present, sig reports the signature.
- Not defined: no MISR register, sig tied to 0; pass/fail_idx behaviour unchanged.

## Structure
- Package gate_bist_pkg holds:
  - state enum
  - LFSR_SEED
  - LFSR_TAPS / MISR_TAPS lookup function indexed by width
  - vector index typedef (16-bit)
- Sub-module gate_bist_lfsr (parameter W=2n): load, advance, q. The controller instantiates it once; the MISR stays inline.

## Test plan
- Reset: hold rst_n=0 → A=B=0, busy=done=pass=0, fail_idx=0, sig=0.
- Ideal gate (F=A&B), n=4, NUM_VEC=16, SETTLE=1, start at edge 0 → vector 0 A=4'hF B=4'hF; vector 1 A=4'hE B=4'h3; done pulse in cycle 33; pass=1, fail_idx=0.
- F[0] stuck-at-0 → vector 0 expects 4'hF, sees 4'hE → pass=0, fail_idx=0; done still in cycle 33.
- Fault injected only on vector 1 (F forced 4'h0 while A=4'hE, B=4'h3) → pass=0, fail_idx=1.
- start pulsed at cycle 5 during a run → ignored, done still in cycle 33. rst_n asserted at cycle 10 → all outputs return to reset values; a restart reproduces vector 0 = F/F.
- Two identical ideal runs with GATE_BIST_MISR_EN → equal nonzero sig; the stuck-at run gives a different sig; without the macro, sig=0 throughout.
